fp_divsqrt_iter: RTL

FP_DIVSQRT_ITER -- requirements
Module: fp_divsqrt_iter

---
 rtl/fp_divsqrt_iter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_divsqrt_iter.sv
// Iterative floating-point divide / square-root core.
// Radix-2 restoring division and restoring square root, one result bit per
// cycle. Special operands bypass the iteration and complete the cycle after
// accept. Rounding happens downstream of this block.
// Build option: define FP_DIVSQRT_ITER_SQRT_EN to include the sqrt datapath;
// without it op_sqrt is ignored and every request is a division.
module fp_divsqrt_iter #(
  parameter int unsigned EXPO_W = 11,
  parameter int unsigned FRAC_W = 52,
  parameter int unsigned ID_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_request,
  input  logic                flush,
  input  logic                op_sqrt,
  input  logic [ID_W-1:0]     id_in,
  input  logic                rs1_sign,
  input  logic                rs2_sign,
  input  logic [EXPO_W-1:0]   rs1_expo,
  input  logic [EXPO_W-1:0]   rs2_expo,
  input  logic [FRAC_W-1:0]   rs1_frac,
  input  logic [FRAC_W-1:0]   rs2_frac,
  input  logic [3:0]          rs1_special,
  input  logic [3:0]          rs2_special,
  output logic                ready,
  output logic                wb_done,
  input  logic                wb_ack,
  output logic [ID_W-1:0]     wb_id,
  output logic                wb_sign,
  output logic [EXPO_W+1:0]   wb_expo,
  output logic [FRAC_W+2:0]   wb_mant,
  output logic                wb_sticky,
  output logic                wb_special,
  output logic                wb_nv,
  output logic                wb_dz
);

  localparam int unsigned N     = FRAC_W + 3;
  localparam int unsigned CNT_W = $clog2(N);
  localparam int unsigned EW    = EXPO_W + 2;
  localparam int unsigned RW    = N + 2;
  localparam int unsigned SP_SNAN = 3;
  localparam int unsigned SP_QNAN = 2;
  localparam int unsigned SP_INF  = 1;
  localparam int unsigned SP_ZERO = 0;
  localparam logic [EW-1:0]    BIAS      = EW'(2 ** (EXPO_W - 1) - 1);
  localparam logic [EW-1:0]    EXPO_MAX  = EW'(2 ** EXPO_W - 1);
  localparam logic [N-1:0]     MANT_QNAN = N'(1) << (N - 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     dsor_q, dsor_d;
  logic [EW-1:0]    expo_q, expo_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             sign_q, sign_d;
  logic             sticky_q, sticky_d;
  logic             special_q, special_d;
  logic             nv_q, nv_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             sp_nv, sp_nan, sp_dz, sp_inf, sp_any, sp_sign;
  logic             div_ge;
  logic [RW-1:0]    div_r, div_rem;

`ifdef FP_DIVSQRT_ITER_SQRT_EN
  logic [2*N-1:0]        rad_q, rad_d;
  logic                  sqrt_q, sqrt_d;
  logic [2*N-1:0]        rad_init;
  logic signed [EW-1:0]  sq_unb, sq_half;
  logic [EW-1:0]         sq_expo;
  logic [N+3:0]          sq_acc, sq_trial, sq_r;
  logic                  sq_ge;
`else
  // op_sqrt has no effect when the sqrt datapath is compiled out
  logic unused_op_sqrt;
  assign unused_op_sqrt = op_sqrt;
`endif

  assign ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & wb_ack);
  assign accept  = new_request & ready & ~flush;
  assign wb_done = (state_q == S_DONE);

  // Classify the incoming request: invalid, NaN, divide-by-zero, infinity, zero
  always_comb begin
    sp_nv   = rs1_special[SP_SNAN] | rs2_special[SP_SNAN]
            | (rs1_special[SP_ZERO] & rs2_special[SP_ZERO])
            | (rs1_special[SP_INF] & rs2_special[SP_INF]);
    sp_nan  = sp_nv | rs1_special[SP_QNAN] | rs2_special[SP_QNAN];
    sp_dz   = ~sp_nan & rs2_special[SP_ZERO] & ~rs1_special[SP_ZERO] & ~rs1_special[SP_INF];
    sp_inf  = ~sp_nan & (rs1_special[SP_INF] | sp_dz);
    sp_any  = (|rs1_special) | (|rs2_special);
    sp_sign = rs1_sign ^ rs2_sign;
`ifdef FP_DIVSQRT_ITER_SQRT_EN
    if (op_sqrt) begin
      sp_nv   = rs1_special[SP_SNAN] | (rs1_sign & ~rs1_special[SP_ZERO] & ~rs1_special[SP_QNAN]);
      sp_nan  = sp_nv | rs1_special[SP_QNAN];
      sp_dz   = 1'b0;
      sp_inf  = ~sp_nan & rs1_special[SP_INF];
      sp_any  = (|rs1_special) | rs1_sign;
      sp_sign = rs1_sign;
    end
`endif
  end

  // One restoring-division step: subtract divisor when it fits, shift remainder
  always_comb begin
    div_ge  = rem_q >= {2'b00, dsor_q};
    div_r   = div_ge ? (rem_q - {2'b00, dsor_q}) : rem_q;
    div_rem = RW'({div_r, 1'b0});
  end

`ifdef FP_DIVSQRT_ITER_SQRT_EN
  // Radicand alignment, halved exponent and one restoring square-root step
  always_comb begin
    sq_unb   = EW'(rs1_expo) - BIAS;
    sq_half  = sq_unb >>> 1;
    sq_expo  = EW'(sq_half) + BIAS;
    rad_init = sq_unb[0] ? {1'b1, rs1_frac, {(FRAC_W + 5){1'b0}}}
                         : {2'b01, rs1_frac, {(FRAC_W + 4){1'b0}}};
    sq_acc   = {rem_q, rad_q[2*N-1 -: 2]};
    sq_trial = {2'b00, quo_q, 2'b01};
    sq_ge    = sq_acc >= sq_trial;
    sq_r     = sq_ge ? (sq_acc - sq_trial) : sq_acc;
  end
`endif

  // Next state and iteration counter; flush overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: if (accept) state_d = sp_any ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DONE: if (wb_ack) state_d = accept ? (sp_any ? S_DONE : S_BUSY) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath: load operands on accept, iterate while busy, hold otherwise
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsor_d    = dsor_q;
    expo_d    = expo_q;
    id_d      = id_q;
    sign_d    = sign_q;
    sticky_d  = sticky_q;
    special_d = special_q;
    nv_d      = nv_q;
    dz_d      = dz_q;
`ifdef FP_DIVSQRT_ITER_SQRT_EN
    rad_d     = rad_q;
    sqrt_d    = sqrt_q;
`endif
    if (accept) begin
      id_d      = id_in;
      special_d = sp_any;
      sticky_d  = 1'b0;
      nv_d      = sp_any & sp_nv;
      dz_d      = sp_any & sp_dz;
      rem_d     = {2'b00, 1'b1, rs1_frac, 2'b00};
      dsor_d    = {1'b1, rs2_frac, 2'b00};
      quo_d     = '0;
      sign_d    = sp_sign;
      expo_d    = EW'(rs1_expo) - EW'(rs2_expo) + BIAS;
`ifdef FP_DIVSQRT_ITER_SQRT_EN
      sqrt_d    = op_sqrt;
      rad_d     = rad_init;
      if (op_sqrt) begin
        rem_d  = '0;
        expo_d = sq_expo;
      end
`endif
      if (sp_any) begin
        if (sp_nan) begin
          sign_d = 1'b0;
          expo_d = EXPO_MAX;
          quo_d  = MANT_QNAN;
        end else if (sp_inf) begin
          expo_d = EXPO_MAX;
        end else begin
          expo_d = '0;
        end
      end
    end else if (state_q == S_BUSY) begin
`ifdef FP_DIVSQRT_ITER_SQRT_EN
      if (sqrt_q) begin
        rem_d = RW'(sq_r);
        quo_d = {quo_q[N-2:0], sq_ge};
        rad_d = {rad_q[2*N-3:0], 2'b00};
      end else begin
        rem_d = div_rem;
        quo_d = {quo_q[N-2:0], div_ge};
      end
`else
      rem_d = div_rem;
      quo_d = {quo_q[N-2:0], div_ge};
`endif
      if (cnt_q == CNT_LAST) sticky_d = |rem_d;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers, no reset needed
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dsor_q    <= dsor_d;
    expo_q    <= expo_d;
    id_q      <= id_d;
    sign_q    <= sign_d;
    sticky_q  <= sticky_d;
    special_q <= special_d;
    nv_q      <= nv_d;
    dz_q      <= dz_d;
`ifdef FP_DIVSQRT_ITER_SQRT_EN
    rad_q     <= rad_d;
    sqrt_q    <= sqrt_d;
`endif
  end

  assign wb_id      = id_q;
  assign wb_sign    = sign_q;
  assign wb_expo    = expo_q;
  assign wb_mant    = quo_q;
  assign wb_sticky  = sticky_q;
  assign wb_special = special_q;
  assign wb_nv      = nv_q;
  assign wb_dz      = dz_q;

endmodule
